// File: rtl/regfile_mp_pkg.sv
// Shared defaults for the multi-port register file.
//
// Holds the default geometry (DSIZE, ASIZE, NREG, NRD), the reset-value
// defaults (INIT_ADDR, INIT_VAL) and the hard-wired-zero register switch.
//
// Build option: REGFILE_MP_R0_ZERO_EN
//   Defined   -> register 0 is hard-wired to zero. It is never written,
//                never pending, never bypassed, and it always reads ready.
//   Undefined -> register 0 behaves like any other register.
package regfile_mp_pkg;

  localparam int DSIZE_DEF     = 16;
  localparam int ASIZE_DEF     = 4;
  localparam int NREG_DEF      = 16;
  localparam int NRD_DEF       = 2;
  localparam int INIT_ADDR_DEF = 1;
  localparam int INIT_VAL_DEF  = 5;

`ifdef REGFILE_MP_R0_ZERO_EN
  localparam bit R0_ZERO_EN = 1'b1;
`else
  localparam bit R0_ZERO_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port of regfile_mp: write-to-read bypass mux plus ready flag.
//
// Ports:
//   raddr            read address for this port
//   wen0/waddr0/...  port 0 (ALU) write, bypass source with lower priority
//   wen1/waddr1/...  port 1 (load) write, bypass source with higher priority
//   regs_flat        all architectural registers, register r at [r*DSIZE +: DSIZE]
//   pend             registered pending bits
//   rdata            zero-latency read data
//   rready           1 = rdata is architecturally current
//
// Build option: REGFILE_MP_R0_ZERO_EN (via regfile_mp_pkg::R0_ZERO_EN).
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic [ASIZE-1:0]      raddr,
  input  logic                  wen0,
  input  logic [ASIZE-1:0]      waddr0,
  input  logic [DSIZE-1:0]      wdata0,
  input  logic                  wen1,
  input  logic [ASIZE-1:0]      waddr1,
  input  logic [DSIZE-1:0]      wdata1,
  input  logic [NREG*DSIZE-1:0] regs_flat,
  input  logic [NREG-1:0]       pend,
  output logic [DSIZE-1:0]      rdata,
  output logic                  rready
);

  logic in_range;
  logic hit0;
  logic hit1;
  logic is_r0;

  always_comb begin
    in_range = ({1'b0, raddr} < (ASIZE+1)'(NREG));
    hit1     = wen1 && (waddr1 == raddr);
    hit0     = wen0 && (waddr0 == raddr);
    is_r0    = R0_ZERO_EN && (raddr == '0);
    rdata    = '0;
    rready   = 1'b1;
    // Out-of-range and hard-wired-zero reads fall through as 0 / ready.
    if (in_range && !is_r0) begin
      // A same-cycle load writeback satisfies the pending load.
      rready = ~pend[raddr] | hit1;
      if (hit1)      rdata = wdata1;
      else if (hit0) rdata = wdata0;
      else           rdata = regs_flat[int'(raddr)*DSIZE +: DSIZE];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode/writeback stages.
//
// Two write ports (0 = ALU writeback, 1 = load writeback; port 1 wins on
// an address collision), NRD combinational read ports with write bypass,
// and a per-register pending scoreboard for outstanding loads.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   wen0/waddr0/wdata0 ALU write port
//   wen1/waddr1/wdata1 load write port, also clears the pending bit
//   raddr/rdata        packed read ports, port k at [k*ASIZE] / [k*DSIZE]
//   rready             per-port "data is current" flag for stall logic
//   pend_set/pend_addr mark a register pending when a load issues
//   pend_vec           registered pending bits
//   waw_err            one-cycle pulse after an ALU write hits a pending reg
//
// Build option: REGFILE_MP_R0_ZERO_EN (register 0 hard-wired to zero).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ASIZE     = ASIZE_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int NRD       = NRD_DEF,
  parameter int INIT_ADDR = INIT_ADDR_DEF,
  parameter int INIT_VAL  = INIT_VAL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen0,
  input  logic [ASIZE-1:0]     waddr0,
  input  logic [DSIZE-1:0]     wdata0,
  input  logic                 wen1,
  input  logic [ASIZE-1:0]     waddr1,
  input  logic [DSIZE-1:0]     wdata1,
  input  logic [NRD*ASIZE-1:0] raddr,
  output logic [NRD*DSIZE-1:0] rdata,
  output logic [NRD-1:0]       rready,
  input  logic                 pend_set,
  input  logic [ASIZE-1:0]     pend_addr,
  output logic [NREG-1:0]      pend_vec,
  output logic                 waw_err
);

  logic [DSIZE-1:0]      regs_q [NREG];
  logic [DSIZE-1:0]      regs_d [NREG];
  logic [NREG-1:0]       pend_q;
  logic [NREG-1:0]       pend_d;
  logic                  waw_q;
  logic                  waw_d;
  logic [NREG*DSIZE-1:0] regs_flat;

  always_comb begin
    pend_d = pend_q;
    waw_d  = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      // Register 0 is frozen at zero when hard-wired; its pending bit stays 0.
      if (!(R0_ZERO_EN && r == 0)) begin
        if (wen1 && waddr1 == ASIZE'(r))      regs_d[r] = wdata1;
        else if (wen0 && waddr0 == ASIZE'(r)) regs_d[r] = wdata0;
        // Set wins over a same-cycle clear: a new load issued as the old one
        // returns keeps the register pending.
        pend_d[r] = (pend_set && pend_addr == ASIZE'(r)) |
                    (pend_q[r] & ~(wen1 && waddr1 == ASIZE'(r)));
      end
      if (wen0 && waddr0 == ASIZE'(r) && pend_q[r]) waw_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == INIT_ADDR && !(R0_ZERO_EN && r == 0)) ? DSIZE'(INIT_VAL) : '0;
      end
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

  assign pend_vec = pend_q;
  assign waw_err  = waw_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DSIZE +: DSIZE] = regs_q[g];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE),
      .NREG  (NREG)
    ) u_rdport (
      .raddr     (raddr[k*ASIZE +: ASIZE]),
      .wen0      (wen0),
      .waddr0    (waddr0),
      .wdata0    (wdata0),
      .wen1      (wen1),
      .waddr1    (waddr1),
      .wdata1    (wdata1),
      .regs_flat (regs_flat),
      .pend      (pend_q),
      .rdata     (rdata[k*DSIZE +: DSIZE]),
      .rready    (rready[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int NP = 2;
`ifdef REGFILE_MP_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wen0, wen1, pend_set;
  logic [AW-1:0]  waddr0, waddr1, pend_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata;
  logic [NP-1:0]  rready;
  logic [NR-1:0]  pend_vec;
  logic           waw_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v, got;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_pend;
  logic          m_waw;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .wen0      (wen0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .wen1      (wen1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .raddr     (raddr),
    .rdata     (rdata),
    .rready    (rready),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .pend_vec  (pend_vec),
    .waw_err   (waw_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    pend_set = 0; pend_addr = '0; raddr = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_regs[1] = 16'd5;
    m_pend = '0;
    m_waw  = 1'b0;
  endtask

  // Advance one clock and update the reference model from the driven inputs.
  task automatic step();
    logic [NR-1:0] np;
    @(posedge clk);
    m_waw = wen0 && m_pend[waddr0];
    np = m_pend;
    if (pend_set && !(R0 && pend_addr == 0)) np[pend_addr] = 1'b1;
    if (wen1 && !(pend_set && pend_addr == waddr1)) np[waddr1] = 1'b0;
    if (wen0 && !(R0 && waddr0 == 0)) m_regs[waddr0] = wdata0;
    if (wen1 && !(R0 && waddr1 == 0)) m_regs[waddr1] = wdata1;
    m_pend = np;
    #1;
  endtask

  // {ready, data} expected on a read port for the currently driven inputs.
  function automatic logic [31:0] mrd(logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic          rdy;
    if (R0 && a == 0) return {15'h0, 1'b1, 16'h0};
    rdy = !m_pend[a] || (wen1 && waddr1 == a);
    if (wen1 && waddr1 == a)      d = wdata1;
    else if (wen0 && waddr0 == a) d = wdata0;
    else                          d = m_regs[a];
    return {15'h0, rdy, d};
  endfunction

  task automatic test_reset();
    wen0 = 1; waddr0 = 4'd2; wdata0 = 16'h1234;
    step(); idle();
    pend_set = 1; pend_addr = 4'd9;
    step(); idle();
    raddr = {4'd2, 4'd0};
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[31:16]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_reset_reg2 got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[9]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_reset_pend9 got=%h exp=%h", got, exp_v); end
    // In-flight write and pend_set, then reset drops mid-cycle.
    wen0 = 1; waddr0 = 4'd2; wdata0 = 16'h5555;
    pend_set = 1; pend_addr = 4'd10;
    #2 rst = 0;
    idle();
    raddr = {4'd2, 4'd1};
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h5);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, pend_vec}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_pend_vec got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, waw_err}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_waw got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_reg1 got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[31:16]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_reg2 got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {30'h0, rready}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_rready got=%h exp=%h", got, exp_v); end
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_reset();
    step();
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[31:16]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL post_reset_reg2 got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_bypass();
    idle();
    wen0 = 1; waddr0 = 4'd3; wdata0 = 16'h00AA; raddr = {4'd0, 4'd3};
    exp_q.push_back(32'h00AA);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL bypass_same got=%h exp=%h", got, exp_v); end
    step(); idle();
    raddr = {4'd0, 4'd3};
    exp_q.push_back(32'h00AA);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL bypass_stored got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_collision();
    idle();
    wen0 = 1; waddr0 = 4'd4; wdata0 = 16'h1111;
    wen1 = 1; waddr1 = 4'd4; wdata1 = 16'h2222;
    raddr = {4'd4, 4'd0};
    exp_q.push_back(32'h2222);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[31:16]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL collide_same got=%h exp=%h", got, exp_v); end
    step(); idle();
    raddr = {4'd4, 4'd4};
    exp_q.push_back(32'h2222);
    exp_q.push_back(32'h2222);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL collide_p0 got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[31:16]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL collide_p1 got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_scoreboard();
    idle();
    pend_set = 1; pend_addr = 4'd6;
    step(); idle();
    raddr = {4'd0, 4'd6};
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[6]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_pend6_set got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, rready[0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_rready_pending got=%h exp=%h", got, exp_v); end
    wen1 = 1; waddr1 = 4'd6; wdata1 = 16'h0BEE;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0BEE);
    #1;
    exp_v = exp_q.pop_front(); got = {31'h0, rready[0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_rready_wb got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_rdata_wb got=%h exp=%h", got, exp_v); end
    step(); idle();
    raddr = {4'd0, 4'd6};
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0BEE);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, pend_vec}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_pend_cleared got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sb_rdata_stored got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_waw();
    idle();
    pend_set = 1; pend_addr = 4'd7;
    wen1 = 1; waddr1 = 4'd7; wdata1 = 16'h7777;
    step(); idle();
    raddr = {4'd0, 4'd7};
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[7]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_set_wins got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, waw_err}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_idle got=%h exp=%h", got, exp_v); end
    wen0 = 1; waddr0 = 4'd7; wdata0 = 16'h0777;
    step(); idle();
    raddr = {4'd0, 4'd7};
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0777);
    #1;
    exp_v = exp_q.pop_front(); got = {31'h0, waw_err}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_pulse got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[7]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_pend_kept got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_data got=%h exp=%h", got, exp_v); end
    step();
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); got = {31'h0, waw_err}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_one_cycle got=%h exp=%h", got, exp_v); end
    // ALU write to a non-pending register must not flag.
    wen0 = 1; waddr0 = 4'd8; wdata0 = 16'h0888;
    wen1 = 1; waddr1 = 4'd7; wdata1 = 16'h0077;
    step(); idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); got = {31'h0, waw_err}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_nonpending got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[7]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL waw_clear7 got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_r0();
    idle();
    wen0 = 1; waddr0 = 4'd0; wdata0 = 16'hFFFF;
    pend_set = 1; pend_addr = 4'd0;
    raddr = {4'd0, 4'd0};
    exp_q.push_back(R0 ? 32'h0 : 32'hFFFF);
    exp_q.push_back(32'h1);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL r0_same got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, rready[0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL r0_rready got=%h exp=%h", got, exp_v); end
    step(); idle();
    raddr = {4'd0, 4'd0};
    exp_q.push_back(R0 ? 32'h0 : 32'hFFFF);
    exp_q.push_back(R0 ? 32'h0 : 32'h1);
    #1;
    exp_v = exp_q.pop_front(); got = {16'h0, rdata[15:0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL r0_stored got=%h exp=%h", got, exp_v); end
    exp_v = exp_q.pop_front(); got = {31'h0, pend_vec[0]}; n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL r0_pend got=%h exp=%h", got, exp_v); end
    wen1 = 1; waddr1 = 4'd0; wdata1 = 16'h0;
    step(); idle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      wen0 = $urandom_range(0, 1); waddr0 = AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
      wen1 = $urandom_range(0, 1); waddr1 = AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
      pend_set = ($urandom_range(0, 3) == 0); pend_addr = AW'($urandom_range(0, 7));
      raddr = {AW'($urandom_range(0, 8)), AW'($urandom_range(0, 8))};
      exp_q.push_back(mrd(raddr[3:0]));
      exp_q.push_back(mrd(raddr[7:4]));
      #1;
      exp_v = exp_q.pop_front(); got = {15'h0, rready[0], rdata[15:0]}; n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rnd_p0 cyc=%0d got=%h exp=%h", c, got, exp_v); end
      exp_v = exp_q.pop_front(); got = {15'h0, rready[1], rdata[31:16]}; n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rnd_p1 cyc=%0d got=%h exp=%h", c, got, exp_v); end
      step();
      exp_q.push_back({15'h0, m_waw, m_pend});
      exp_v = exp_q.pop_front(); got = {15'h0, waw_err, pend_vec}; n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rnd_state cyc=%0d got=%h exp=%h", c, got, exp_v); end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    #12 rst = 1;
    step();
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_waw();
    test_r0();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with 2 write ports and NRD read ports.
- Combinational write-to-read bypass on every read port.
- Per-register pending scoreboard: a register is marked pending when a long-latency (load) result is issued and cleared when that result writes back on port 1.
- Sits in the decode/writeback stages of the pipeline; the stall logic consumes the per-port ready flags.

Parameters:
- DSIZE, 16, data width in bits.
- ASIZE, 4, register address width.
- NREG, 16, number of registers (NREG <= 2**ASIZE).
- NRD, 2, number of read ports.
- INIT_ADDR, 1, register given a non-zero reset value.
- INIT_VAL, 5, reset value of register INIT_ADDR; all other registers reset to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- wen0  in  1  write enable, port 0 (ALU writeback).
- waddr0  in  ASIZE  write address, port 0.
- wdata0  in  DSIZE  write data, port 0.
- wen1  in  1  write enable, port 1 (load writeback).
- waddr1  in  ASIZE  write address, port 1.
- wdata1  in  DSIZE  write data, port 1.
- raddr  in  NRD*ASIZE  read addresses; port k occupies bits [k*ASIZE +: ASIZE].
- rdata  out  NRD*DSIZE  read data, packed the same way.
- rready  out  NRD  1 = rdata[k] is architecturally current.
- pend_set  in  1  mark register pend_addr pending (load issued).
- pend_addr  in  ASIZE  register to mark pending.
- pend_vec  out  NREG  registered pending bits.
- waw_err  out  1  registered one-cycle pulse flagging a write-after-write hazard (see Behaviour).

Behaviour:
- Reset (rst=0, asynchronous): regs[INIT_ADDR]=INIT_VAL, all other regs=0, pend_vec=0, waw_err=0. Asserting reset mid-operation discards any in-flight write and pending state immediately.
- Writes: on the rising clk edge, wenN=1 stores wdataN into regs[waddrN]. Addresses >= NREG are ignored for both data and pending state.
- Dual-write collision (wen0 & wen1 & waddr0==waddr1): port 1 wins; the port 0 data is dropped.
- Read port k is combinational, zero latency, with priority:
  - wen1 & waddr1==raddr_k -> wdata1;
  - else wen0 & waddr0==raddr_k -> wdata0;
  - else regs[raddr_k].
  - raddr_k >= NREG reads 0, with rready=1.
- rready[k] = ~pend_vec[raddr_k] | (wen1 & waddr1==raddr_k). A same-cycle load writeback therefore counts as ready.
- Scoreboard update per register r, each cycle:
  - set = pend_set & pend_addr==r;
  - clr = wen1 & waddr1==r;
  - next = set | (pend & ~clr). Set wins over a simultaneous clear.
- pend_set on an already-pending register leaves it pending; only one outstanding load per register is tracked.
- wen1 to a non-pending register writes data normally; pend_vec is unchanged.
- waw_err: asserts for exactly one cycle, the cycle after wen0 targets a register that is pending at that edge. The data is written; the pending bit stays set.
- No internal FSM beyond the per-register pending bits and the waw_err flop. All outputs except rdata/rready are registered.

Optional Feature:
- Macro: REGFILE_MP_R0_ZERO_EN.
- Defined:
  - register 0 always reads 0 with rready=1 and is never bypassed;
  - writes to register 0 are discarded;
  - pend_set to register 0 is ignored, so pend_vec[0] is always 0;
  - INIT_ADDR=0 has no effect.
- Undefined: register 0 behaves like any other register.

Decomposition:
- Shared package/define file holds DSIZE, ASIZE, NREG and NRD defaults, and the INIT_ADDR/INIT_VAL defaults.
- Sub-module regfile_mp_rdport: one read port's bypass mux plus its rready logic, instantiated NRD times in a generate loop.

Test Plan:
- Reset: pulse rst=0 mid-cycle -> all outputs clear immediately; read reg1=5, reg2=0; pend_vec=0.
- Bypass: wen0=1, waddr0=3, wdata0=0x00AA, raddr port0=3 in the same cycle -> rdata port0=0x00AA. The next cycle reads 0x00AA from storage.
- Collision: wen0/wen1 both to reg 4, wdata0=0x1111, wdata1=0x2222 -> same-cycle read and later reads give 0x2222.
- Scoreboard:
  - pend_set reg 6 -> next cycle pend_vec[6]=1, rready=0 for raddr=6;
  - wen1 reg6 wdata1=0x0BEE -> same cycle rready=1, rdata=0x0BEE; next cycle pend_vec[6]=0.
- Simultaneous events and WAW:
  - pend_set reg 7 together with wen1 reg 7 -> pend_vec[7]=1 afterwards;
  - a later wen0 to reg 7 -> waw_err=1 for exactly one cycle.
- With REGFILE_MP_R0_ZERO_EN: wen0 reg0 0xFFFF and pend_set reg0 -> read reg0 returns 0, rready=1, pend_vec[0]=0.
